// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcode/funct values,
// ALU operand-mux selects, ALU operations and the registered control bundle.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 3;

  localparam logic [STATE_W-1:0] S_FETCH   = 4'd0;
  localparam logic [STATE_W-1:0] S_DECODE  = 4'd1;
  localparam logic [STATE_W-1:0] S_EXEC_R  = 4'd2;
  localparam logic [STATE_W-1:0] S_WB_R    = 4'd3;
  localparam logic [STATE_W-1:0] S_EXEC_I  = 4'd4;
  localparam logic [STATE_W-1:0] S_WB_I    = 4'd5;
  localparam logic [STATE_W-1:0] S_ADDR    = 4'd6;
  localparam logic [STATE_W-1:0] S_MEM_RD  = 4'd7;
  localparam logic [STATE_W-1:0] S_MEM_WB  = 4'd8;
  localparam logic [STATE_W-1:0] S_MEM_WR  = 4'd9;
  localparam logic [STATE_W-1:0] S_BRANCH  = 4'd10;
  localparam logic [STATE_W-1:0] S_JUMP    = 4'd11;
  localparam logic [STATE_W-1:0] S_ADDM_RD = 4'd12;
  localparam logic [STATE_W-1:0] S_ADDM_EX = 4'd13;
  localparam logic [STATE_W-1:0] S_ILLEGAL = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDM  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [1:0] SRCA_PC  = 2'd0;
  localparam logic [1:0] SRCA_A   = 2'd1;
  localparam logic [1:0] SRCA_MDR = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       aluout_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
    logic [2:0] op;
    case (funct)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // First execution microstep chosen from DECODE.
  function automatic logic [STATE_W-1:0] dispatch(input logic [5:0] opcode,
                                                  input logic [5:0] funct);
    logic [STATE_W-1:0] s;
    case (opcode)
      OP_RTYPE:     s = (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) ?
                        S_EXEC_R : S_ILLEGAL;
      OP_ADDI:      s = S_EXEC_I;
      OP_LW, OP_SW: s = S_ADDR;
      OP_BEQ:       s = S_BRANCH;
      OP_J:         s = S_JUMP;
      OP_ADDM:      s = S_ADDM_RD;
      default:      s = S_ILLEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_wait_cnt.sv
// Wait counter for memory microsteps: counts cycles since state entry (saturating)
// and flags when the count reaches MEM_WAIT, both now and for the coming cycle.
module mc_wait_cnt
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_done,
  output logic o_done_nxt_c
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != {CNT_W{1'b1}}) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_done       = (r_cnt == CNT_W'(MEM_WAIT));
  assign o_done_nxt_c = (w_cnt_nxt == CNT_W'(MEM_WAIT));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: one state per microstep, driving the ALU operand muxes and
// datapath write enables. Controls are registered from the next-state decode.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       ab_write,
  output logic       aluout_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic               r_boot;
  logic               w_clear;
  logic               w_done;
  logic               w_done_nxt;
  ctrl_t              r_ctrl;
  ctrl_t              w_ctrl_nxt;
  logic               w_unused;

  // The branch decision is made in the datapath by gating pc_write_cond with zero.
  assign w_unused = zero;

  mc_wait_cnt #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait_cnt (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_clear),
    .o_done       (w_done),
    .o_done_nxt_c (w_done_nxt)
  );

  // Next state; the cycle leaving reset re-enters FETCH so its counter starts clean.
  always_comb begin
    w_state_nxt = r_state;
    if (r_boot) begin
      w_state_nxt = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   if (w_done) w_state_nxt = S_DECODE;
        S_DECODE:  w_state_nxt = dispatch(opcode, funct);
        S_EXEC_R:  w_state_nxt = S_WB_R;
        S_EXEC_I:  w_state_nxt = S_WB_I;
        S_ADDR:    w_state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:  if (w_done) w_state_nxt = S_MEM_WB;
        S_MEM_WR:  if (w_done) w_state_nxt = S_FETCH;
        S_ADDM_RD: if (w_done) w_state_nxt = S_ADDM_EX;
        S_ADDM_EX: w_state_nxt = S_WB_R;
        default:   w_state_nxt = S_FETCH;
      endcase
    end
  end

  assign w_clear = r_boot || (w_state_nxt != r_state);

  // Controls for the coming cycle, so the registered outputs line up with r_state.
  always_comb begin
    w_ctrl_nxt = '0;
    case (w_state_nxt)
      S_FETCH: begin
        if (w_done_nxt) begin
          w_ctrl_nxt.ir_write  = 1'b1;
          w_ctrl_nxt.pc_write  = 1'b1;
          w_ctrl_nxt.alu_src_a = SRCA_PC;
          w_ctrl_nxt.alu_src_b = SRCB_FOUR;
          w_ctrl_nxt.alu_op    = ALU_ADD;
          w_ctrl_nxt.pc_source = PCSRC_ALU;
        end
      end
      S_DECODE: begin
        w_ctrl_nxt.ab_write     = 1'b1;
        w_ctrl_nxt.aluout_write = 1'b1;
        w_ctrl_nxt.alu_src_a    = SRCA_PC;
        w_ctrl_nxt.alu_src_b    = SRCB_IMM_SH;
      end
      S_EXEC_R: begin
        w_ctrl_nxt.alu_src_a    = SRCA_A;
        w_ctrl_nxt.alu_src_b    = SRCB_B;
        w_ctrl_nxt.alu_op       = funct_alu_op(funct);
        w_ctrl_nxt.aluout_write = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        w_ctrl_nxt.alu_src_a    = SRCA_A;
        w_ctrl_nxt.alu_src_b    = SRCB_IMM;
        w_ctrl_nxt.alu_op       = ALU_ADD;
        w_ctrl_nxt.aluout_write = 1'b1;
      end
      S_WB_R: begin
        w_ctrl_nxt.reg_write = 1'b1;
        w_ctrl_nxt.reg_dst   = 1'b1;
      end
      S_WB_I: w_ctrl_nxt.reg_write = 1'b1;
      S_MEM_RD, S_ADDM_RD: begin
        w_ctrl_nxt.i_or_d    = 1'b1;
        w_ctrl_nxt.mdr_write = w_done_nxt;
      end
      S_MEM_WB: begin
        w_ctrl_nxt.reg_write  = 1'b1;
        w_ctrl_nxt.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        w_ctrl_nxt.i_or_d    = 1'b1;
        w_ctrl_nxt.mem_write = w_clear;
      end
      S_BRANCH: begin
        w_ctrl_nxt.alu_src_a     = SRCA_A;
        w_ctrl_nxt.alu_src_b     = SRCB_B;
        w_ctrl_nxt.alu_op        = ALU_SUB;
        w_ctrl_nxt.pc_write_cond = 1'b1;
        w_ctrl_nxt.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        w_ctrl_nxt.pc_write  = 1'b1;
        w_ctrl_nxt.pc_source = PCSRC_JUMP;
      end
      S_ADDM_EX: begin
        w_ctrl_nxt.alu_src_a    = SRCA_MDR;
        w_ctrl_nxt.alu_src_b    = SRCB_B;
        w_ctrl_nxt.alu_op       = ALU_ADD;
        w_ctrl_nxt.aluout_write = 1'b1;
      end
      S_ILLEGAL: w_ctrl_nxt.illegal_op = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_boot  <= 1'b1;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_boot  <= 1'b0;
      r_ctrl  <= w_ctrl_nxt;
    end
  end

  assign alu_src_a     = r_ctrl.alu_src_a;
  assign alu_src_b     = r_ctrl.alu_src_b;
  assign alu_op        = r_ctrl.alu_op;
  assign pc_write      = r_ctrl.pc_write;
  assign pc_write_cond = r_ctrl.pc_write_cond;
  assign pc_source     = r_ctrl.pc_source;
  assign i_or_d        = r_ctrl.i_or_d;
  assign mem_write     = r_ctrl.mem_write;
  assign ir_write      = r_ctrl.ir_write;
  assign mdr_write     = r_ctrl.mdr_write;
  assign ab_write      = r_ctrl.ab_write;
  assign aluout_write  = r_ctrl.aluout_write;
  assign reg_write     = r_ctrl.reg_write;
  assign reg_dst       = r_ctrl.reg_dst;
  assign mem_to_reg    = r_ctrl.mem_to_reg;
  assign illegal_op    = r_ctrl.illegal_op;

endmodule
